// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store initiator between core datapath and dmem byte port
//
// Purpose:
//   Accepts one load/store request at a time, drives the dmem byte-addressed
//   port (size, extend, lane-steered write data) and returns the result on a
//   response channel that is held until the core accepts it.
//   Optional feature macro MISALIGN_EN: when defined, misaligned loads become
//   two aligned word reads and misaligned stores become a sequence of byte
//   writes. When undefined, misaligned requests return resp_err=1.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_we, req_size, req_unsigned  store flag, 00/01/10 size (11 illegal), LBU/LHU
//   req_addr, req_wdata             byte address, right-justified store data
//   resp_valid/resp_ready           held response handshake
//   resp_rdata, resp_err            extended load data, error flag
//   mem_we, mem_write_size,
//   mem_read_size,
//   mem_unsigned_extend, mem_addr,
//   mem_wd                          dmem controls, address, lane-steered data
//   mem_rd                          dmem combinational read data

module lsu_ctrl #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  mem_we,
    output logic [1:0]            mem_write_size,
    output logic [1:0]            mem_read_size,
    output logic                  mem_unsigned_extend,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wd,
    input  logic [31:0]           mem_rd
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
        S_RESP   = 3'd2,
        S_LD_LO  = 3'd3,
        S_LD_HI  = 3'd4,
        S_SBYTE  = 3'd5
    } state_t;

    state_t                  state;
    logic                    we_q;
    logic [1:0]              size_q;
    logic                    uns_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             wdata_q;
    logic [31:0]             w0_q;
    logic [1:0]              cnt_q;

    logic                    req_misaligned;
    logic [ADDR_WIDTH-1:0]   base_addr;
    logic [31:0]             mis_word;
    logic [31:0]             mis_rdata;
    logic [7:0]              split_byte;
    logic [1:0]              split_last;

    assign req_ready = (state == S_IDLE);

    assign req_misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                            ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

    assign base_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign split_last = (size_q == 2'b01) ? 2'd1 : 2'd3;

    // Misaligned load result: the two captured words form a 64-bit window
    // {W1,W0}; shifting it right by the byte offset leaves the requested
    // bytes right-justified. mem_rd carries W1 during LD_HI.
    always_comb begin
        mis_word = w0_q;
        case (addr_q[1:0])
            2'd0: mis_word = w0_q;
            2'd1: mis_word = {mem_rd[7:0],  w0_q[31:8]};
            2'd2: mis_word = {mem_rd[15:0], w0_q[31:16]};
            2'd3: mis_word = {mem_rd[23:0], w0_q[31:24]};
            default: mis_word = w0_q;
        endcase
        mis_rdata = mis_word;
        if (size_q == 2'b01) begin
            mis_rdata = uns_q ? {16'h0000, mis_word[15:0]}
                              : {{16{mis_word[15]}}, mis_word[15:0]};
        end
    end

    always_comb begin
        split_byte = wdata_q[7:0];
        case (cnt_q)
            2'd0: split_byte = wdata_q[7:0];
            2'd1: split_byte = wdata_q[15:8];
            2'd2: split_byte = wdata_q[23:16];
            2'd3: split_byte = wdata_q[31:24];
            default: split_byte = wdata_q[7:0];
        endcase
    end

    // dmem controls are decoded from the registered state so that an
    // asynchronous reset drops mem_we in the same cycle.
    always_comb begin
        mem_we              = 1'b0;
        mem_write_size      = 2'b10;
        mem_read_size       = 2'b10;
        mem_unsigned_extend = 1'b0;
        mem_addr            = '0;
        mem_wd              = 32'h0;
        case (state)
            S_ACCESS: begin
                mem_we              = we_q;
                mem_write_size      = size_q;
                mem_read_size       = size_q;
                mem_unsigned_extend = uns_q;
                mem_addr            = addr_q;
                case (size_q)
                    2'b00:   mem_wd = {4{wdata_q[7:0]}};
                    2'b01:   mem_wd = {2{wdata_q[15:0]}};
                    default: mem_wd = wdata_q;
                endcase
            end
            S_LD_LO: begin
                mem_addr = base_addr;
            end
            S_LD_HI: begin
                mem_addr = base_addr + ADDR_WIDTH'(4);
            end
            S_SBYTE: begin
                mem_we         = 1'b1;
                mem_write_size = 2'b00;
                mem_read_size  = 2'b00;
                mem_addr       = addr_q + {{(ADDR_WIDTH-2){1'b0}}, cnt_q};
                mem_wd         = {4{split_byte}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            we_q       <= 1'b0;
            size_q     <= 2'b10;
            uns_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            w0_q       <= 32'h0;
            cnt_q      <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q       <= req_we;
                        size_q     <= req_size;
                        uns_q      <= req_unsigned;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        cnt_q      <= 2'd0;
                        resp_rdata <= 32'h0;
                        resp_err   <= 1'b0;
                        if (req_size == 2'b11) begin
                            resp_err   <= 1'b1;
                            resp_valid <= 1'b1;
                            state      <= S_RESP;
                        end else if (req_misaligned) begin
`ifdef MISALIGN_EN
                            state <= req_we ? S_SBYTE : S_LD_LO;
`else
                            resp_err   <= 1'b1;
                            resp_valid <= 1'b1;
                            state      <= S_RESP;
`endif
                        end else begin
                            state <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    if (!we_q) begin
                        resp_rdata <= mem_rd;
                    end
                    resp_valid <= 1'b1;
                    state      <= S_RESP;
                end
                S_LD_LO: begin
                    w0_q  <= mem_rd;
                    state <= S_LD_HI;
                end
                S_LD_HI: begin
                    resp_rdata <= mis_rdata;
                    resp_valid <= 1'b1;
                    state      <= S_RESP;
                end
                S_SBYTE: begin
                    if (cnt_q == split_last) begin
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
